// File: rtl/ne555_pkg.sv
// Shared types and constants for the NE555 step sequencer: FSM states,
// timer mode codes and the layout of one 19-bit step table entry.
package ne555_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ARM    = 3'd2,
        ST_RUN    = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_t;

    localparam logic [1:0] MODE_MONO  = 2'b00;
    localparam logic [1:0] MODE_AST   = 2'b01;
    localparam logic [1:0] MODE_PWM   = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    localparam int ENTRY_W  = 19;
    localparam int DUR_LSB  = 0;
    localparam int DUR_W    = 8;
    localparam int DUTY_LSB = 8;
    localparam int DUTY_W   = 4;
    localparam int RATE_LSB = 12;
    localparam int RATE_W   = 4;
    localparam int MODE_LSB = 16;
    localparam int MODE_W   = 2;
    localparam int LAST_BIT = 18;

    typedef struct packed {
        logic              last;
        logic [MODE_W-1:0] mode;
        logic [RATE_W-1:0] rate;
        logic [DUTY_W-1:0] duty;
        logic [DUR_W-1:0]  dur;
    } seq_entry_t;

    // A programmed duration of zero still plays for one base tick.
    function automatic logic [DUR_W-1:0] dur_eff(input logic [DUR_W-1:0] dur);
        dur_eff = (dur == 8'd0) ? 8'd1 : dur;
    endfunction

endpackage

// File: rtl/ne555_seq_table.sv
// Step table: DEPTH x 19-bit register file, one write port, one
// combinational read port; a same-cycle read of a written address sees old data.
module ne555_seq_table
    import ne555_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  seq_entry_t    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output seq_entry_t    o_rd_data
);

    seq_entry_t r_mem [DEPTH];

    // Storage with synchronous clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ne555_seq_ctrl.sv
// Step sequencer driving the control inputs of one NE555EX-style timer core:
// plays table entries in order, optionally looping, with tmr_done feedback on mono steps.
module ne555_seq_ctrl
    import ne555_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 256,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [ENTRY_W-1:0] i_wr_data,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_loop_en,
    input  logic               i_clear_err,
    input  logic               i_tmr_done,
    output logic               o_tmr_en,
    output logic [1:0]         o_tmr_mode,
    output logic [3:0]         o_tmr_rate,
    output logic [3:0]         o_tmr_duty,
    output logic               o_tmr_fire,
    output logic               o_tmr_sync,
    output logic               o_busy,
    output logic               o_seq_done,
    output logic [AW-1:0]      o_step_idx,
    output logic               o_timeout_err
);

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [AW-1:0]    r_ptr;
    logic [1:0]       r_mode;
    logic [3:0]       r_rate;
    logic [3:0]       r_duty;
    logic [7:0]       r_dur;
    logic             r_last;
    logic [PW-1:0]    r_pre;
    logic [7:0]       r_dur_cnt;
    logic             r_done_prev;
    logic             r_timeout_err;

    seq_entry_t       w_wr_entry;
    seq_entry_t       w_rd_entry;
    logic             w_in_run;
    logic             w_tick;
    logic             w_dur_hit;
    logic             w_done_rise;
    logic             w_is_mono;
    logic             w_step_end;
    logic             w_timeout;
    logic             w_final;
    logic             w_busy;
    logic             w_en;
    logic             w_sync;
    logic             w_fire;
    logic             w_seq_done;

    assign w_wr_entry = i_wr_data;

    ne555_seq_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_ptr),
        .o_rd_data (w_rd_entry)
    );

    // abort masks every step-end event so it can never count as done or timeout
    assign w_in_run    = (r_state == ST_RUN) && !i_abort;
    assign w_tick      = (r_pre == PRE_LAST);
    assign w_dur_hit   = w_tick && (r_dur_cnt == (dur_eff(r_dur) - 8'd1));
    assign w_done_rise = i_tmr_done && !r_done_prev;
    assign w_is_mono   = (r_mode == MODE_MONO);
    assign w_step_end  = w_in_run && (w_is_mono ? (w_done_rise || w_dur_hit) : w_dur_hit);
    assign w_timeout   = w_in_run && w_is_mono && w_dur_hit && !w_done_rise;
    assign w_final     = r_last || (r_ptr == PTR_LAST);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (i_abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_next_state = i_start ? ST_LOAD : ST_IDLE;
                ST_LOAD:   w_next_state = ST_ARM;
                ST_ARM:    w_next_state = ST_RUN;
                ST_RUN: begin
                    if (w_step_end) begin
                        w_next_state = (w_final && !i_loop_en) ? ST_FINISH : ST_LOAD;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_FINISH: w_next_state = ST_IDLE;
                default:   w_next_state = ST_IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        w_busy     = 1'b0;
        w_en       = 1'b0;
        w_sync     = 1'b0;
        w_fire     = 1'b0;
        w_seq_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
            end
            ST_LOAD: begin
                w_busy = 1'b1;
            end
            ST_ARM: begin
                w_busy = 1'b1;
                w_en   = 1'b1;
                w_sync = 1'b1;
                w_fire = w_is_mono;
            end
            ST_RUN: begin
                w_busy = 1'b1;
                w_en   = 1'b1;
            end
            ST_FINISH: begin
                w_busy     = 1'b1;
                w_seq_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Step pointer and active-step registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr  <= {AW{1'b0}};
            r_mode <= 2'b00;
            r_rate <= 4'd0;
            r_duty <= 4'd0;
            r_dur  <= 8'd0;
            r_last <= 1'b0;
        end else begin
            if (i_abort) begin
                r_ptr <= {AW{1'b0}};
            end else if ((r_state == ST_IDLE) && i_start) begin
                r_ptr <= {AW{1'b0}};
            end else if (w_step_end) begin
                if (!w_final) begin
                    r_ptr <= r_ptr + {{(AW-1){1'b0}}, 1'b1};
                end else if (i_loop_en) begin
                    r_ptr <= {AW{1'b0}};
                end else begin
                    r_ptr <= r_ptr;
                end
            end else begin
                r_ptr <= r_ptr;
            end
            if (r_state == ST_LOAD) begin
                r_mode <= w_rd_entry.mode;
                r_rate <= w_rd_entry.rate;
                r_duty <= w_rd_entry.duty;
                r_dur  <= w_rd_entry.dur;
                r_last <= w_rd_entry.last;
            end
        end
    end

    // Prescaler, duration counter, done-edge history and sticky timeout flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pre         <= {PW{1'b0}};
            r_dur_cnt     <= 8'd0;
            r_done_prev   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done_prev <= i_tmr_done;
            if (r_state == ST_LOAD) begin
                r_pre     <= {PW{1'b0}};
                r_dur_cnt <= 8'd0;
            end else if (r_state == ST_RUN) begin
                r_pre     <= w_tick ? {PW{1'b0}} : r_pre + {{(PW-1){1'b0}}, 1'b1};
                r_dur_cnt <= w_tick ? r_dur_cnt + 8'd1 : r_dur_cnt;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (i_clear_err) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign o_busy        = w_busy;
    assign o_tmr_en      = w_en;
    assign o_tmr_sync    = w_sync;
    assign o_tmr_fire    = w_fire;
    assign o_seq_done    = w_seq_done;
    assign o_tmr_mode    = r_mode;
    assign o_tmr_rate    = r_rate;
    assign o_tmr_duty    = r_duty;
    assign o_step_idx    = r_ptr;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ne555_seq_ctrl.sv
// Bench for ne555_seq_ctrl: a checkpoint table for the basic two-step run, a
// schedule model that expands a step table into per-cycle expected outputs, and directed corner cases.
module tb_ne555_seq_ctrl;
    import ne555_pkg::*;

    localparam int DEPTH = 8;
    localparam int TD    = 4;

    logic        clk = 1'b0;
    logic        rst, wr_en, start, abort, loop_en, clear_err, tmr_done;
    logic [2:0]  wr_addr;
    logic [18:0] wr_data;
    logic        o_tmr_en, o_tmr_fire, o_tmr_sync, o_busy, o_seq_done, o_timeout_err;
    logic [1:0]  o_tmr_mode;
    logic [3:0]  o_tmr_rate, o_tmr_duty;
    logic [2:0]  o_step_idx;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ne555_seq_ctrl #(.DEPTH(DEPTH), .TICK_DIV(TD)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_start(start), .i_abort(abort), .i_loop_en(loop_en), .i_clear_err(clear_err),
        .i_tmr_done(tmr_done), .o_tmr_en(o_tmr_en), .o_tmr_mode(o_tmr_mode),
        .o_tmr_rate(o_tmr_rate), .o_tmr_duty(o_tmr_duty), .o_tmr_fire(o_tmr_fire),
        .o_tmr_sync(o_tmr_sync), .o_busy(o_busy), .o_seq_done(o_seq_done),
        .o_step_idx(o_step_idx), .o_timeout_err(o_timeout_err)
    );

    typedef struct {
        logic       busy, en, sync, fire, sdone;
        logic [2:0] idx;
        logic [1:0] mode;
        logic [3:0] rate, duty;
        logic       err, din;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [18:0] v;
    } cp_t;

    exp_t        q[$];
    logic [18:0] tbl [DEPTH];
    int          plan [DEPTH];
    logic [1:0]  m_mode;
    logic [3:0]  m_rate, m_duty;
    logic        m_err;

    function automatic logic [18:0] mk(input logic b, e, s, f, d, input logic [2:0] i,
                                       input logic [1:0] m, input logic [3:0] r, u, input logic er);
        return {b, e, s, f, d, i, m, r, u, er};
    endfunction

    function automatic logic [18:0] act_vec();
        return {o_busy, o_tmr_en, o_tmr_sync, o_tmr_fire, o_seq_done, o_step_idx,
                o_tmr_mode, o_tmr_rate, o_tmr_duty, o_timeout_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wr_entry(input int a, input logic [18:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = d; tbl[a] = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic start_pulse();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic wait_sync(input logic [2:0] idx, input string nm);
        int n = 0;
        do begin
            @(negedge clk); n++;
        end while (!(o_tmr_sync && o_step_idx == idx) && n < 300);
        check(nm, {31'd0, (o_tmr_sync && o_step_idx == idx)}, 32'd1);
    endtask

    task automatic push_rec(input logic b, e, s, f, d, input int p, input logic din);
        exp_t r;
        r.busy = b; r.en = e; r.sync = s; r.fire = f; r.sdone = d; r.idx = 3'(p);
        r.mode = m_mode; r.rate = m_rate; r.duty = m_duty; r.err = m_err; r.din = din;
        q.push_back(r);
    endtask

    // Expand the table into the per-cycle schedule: LOAD, ARM, RUN*n per step, then FINISH, IDLE.
    task automatic build_trace();
        int p = 0, de, n;
        logic [18:0] e;
        bit hit, to, fin = 1'b0;
        q.delete();
        while (!fin) begin
            e  = tbl[p];
            de = (e[7:0] == 8'd0) ? 1 : int'(e[7:0]);
            push_rec(1, 0, 0, 0, 0, p, 0);
            m_mode = e[17:16]; m_rate = e[15:12]; m_duty = e[11:8];
            push_rec(1, 1, 1, (m_mode == MODE_MONO), 0, p, 0);
            hit = (m_mode == MODE_MONO) && (plan[p] >= 0) && (plan[p] < de * TD);
            n   = hit ? plan[p] + 1 : de * TD;
            to  = (m_mode == MODE_MONO) && !hit;
            for (int k = 0; k < n; k++) push_rec(1, 1, 0, 0, 0, p, hit && (k == plan[p]));
            if (to) m_err = 1'b1;
            fin = e[18] || (p == DEPTH - 1);
            if (fin) begin
                push_rec(1, 0, 0, 0, 1, p, 0);
                push_rec(0, 0, 0, 0, 0, p, 0);
            end else begin
                p++;
            end
        end
    endtask

    task automatic run_trace(input string nm);
        @(posedge clk); #1; start = 1'b1;
        foreach (q[i]) begin
            @(posedge clk); #1;
            start = 1'b0; tmr_done = q[i].din;
            @(negedge clk);
            check(nm, {13'd0, act_vec()},
                  {13'd0, mk(q[i].busy, q[i].en, q[i].sync, q[i].fire, q[i].sdone, q[i].idx,
                             q[i].mode, q[i].rate, q[i].duty, q[i].err)});
        end
        tmr_done = 1'b0;
    endtask

    task automatic clear_err_pulse();
        @(posedge clk); #1; clear_err = 1'b1;
        @(posedge clk); #1; clear_err = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        check("err clear", {31'd0, o_timeout_err}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cp_t cp[10];
        int  k, cyc, n, arms, dones, early;
        logic [5:0] seq_bits;

        rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 19'd0; start = 1'b0;
        abort = 1'b0; loop_en = 1'b0; clear_err = 1'b0; tmr_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin tbl[i] = 19'd0; plan[i] = -1; end
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        check("reset outputs", {13'd0, act_vec()}, 32'd0);

        // Two-step run against a checkpoint table (cycle 0 = start sampled)
        cp[0] = '{1,  mk(1, 0, 0, 0, 0, 3'd0, 2'b00, 4'd0, 4'd0, 0)};
        cp[1] = '{2,  mk(1, 1, 1, 0, 0, 3'd0, 2'b01, 4'd2, 4'd0, 0)};
        cp[2] = '{3,  mk(1, 1, 0, 0, 0, 3'd0, 2'b01, 4'd2, 4'd0, 0)};
        cp[3] = '{14, mk(1, 1, 0, 0, 0, 3'd0, 2'b01, 4'd2, 4'd0, 0)};
        cp[4] = '{15, mk(1, 0, 0, 0, 0, 3'd1, 2'b01, 4'd2, 4'd0, 0)};
        cp[5] = '{16, mk(1, 1, 1, 0, 0, 3'd1, 2'b10, 4'd1, 4'd8, 0)};
        cp[6] = '{17, mk(1, 1, 0, 0, 0, 3'd1, 2'b10, 4'd1, 4'd8, 0)};
        cp[7] = '{24, mk(1, 1, 0, 0, 0, 3'd1, 2'b10, 4'd1, 4'd8, 0)};
        cp[8] = '{25, mk(1, 0, 0, 0, 1, 3'd1, 2'b10, 4'd1, 4'd8, 0)};
        cp[9] = '{26, mk(0, 0, 0, 0, 0, 3'd1, 2'b10, 4'd1, 4'd8, 0)};
        wr_entry(0, {1'b0, MODE_AST, 4'd2, 4'd0, 8'd3});
        wr_entry(1, {1'b1, MODE_PWM, 4'd1, 4'd8, 8'd2});
        @(posedge clk); #1; start = 1'b1;
        k = 0; cyc = 0;
        while (k < 10 && cyc < 60) begin
            @(posedge clk); cyc++;
            #1; start = 1'b0;
            @(negedge clk);
            if (cyc == cp[k].cyc) begin
                check($sformatf("two-step cyc%0d", cyc), {13'd0, act_vec()}, {13'd0, cp[k].v});
                k++;
            end
        end
        check("two-step checkpoints reached", k, 10);
        m_mode = MODE_PWM; m_rate = 4'd1; m_duty = 4'd8; m_err = 1'b0;

        // Mono step: done rise well before, exactly at, and never before the timeout
        wr_entry(0, {1'b1, MODE_MONO, 4'd3, 4'd5, 8'd10});
        plan[0] = 19; build_trace(); run_trace("mono early done");
        plan[0] = 39; build_trace(); run_trace("mono done at timeout");
        plan[0] = -1; build_trace(); run_trace("mono timeout");
        clear_err_pulse();

        // dur=0 entries with no last flag play all DEPTH steps
        for (int i = 0; i < DEPTH; i++) begin
            wr_entry(i, {1'b0, MODE_AST, 4'(i), 4'(7 - i), 8'd0});
            plan[i] = -1;
        end
        build_trace(); run_trace("dur0 full table");

        // Random tables against the schedule model
        for (int it = 0; it < 15; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                logic [7:0] dur;
                logic [1:0] mode;
                int de;
                dur  = 8'($urandom_range(0, 3));
                mode = 2'($urandom_range(0, 3));
                de   = (dur == 8'd0) ? 1 : int'(dur);
                wr_entry(a, {($urandom_range(0, 3) == 0), mode, 4'($urandom), 4'($urandom), dur});
                plan[a] = (mode == MODE_MONO && $urandom_range(0, 1) == 1) ?
                          int'($urandom_range(0, de * TD - 1)) : -1;
            end
            clear_err_pulse();
            build_trace(); run_trace("random");
        end

        // Looping: 0,1,0,1,0,1 then drop loop_en during the final step
        wr_entry(0, {1'b0, MODE_AST, 4'd1, 4'd1, 8'd1});
        wr_entry(1, {1'b1, MODE_PWM, 4'd2, 4'd2, 8'd1});
        loop_en = 1'b1;
        start_pulse();
        arms = 0; dones = 0; early = 0; n = 0; seq_bits = 6'd0;
        while (n < 300 && !(dones > 0 && !o_busy)) begin
            @(negedge clk); n++;
            if (o_tmr_sync) begin
                if (arms < 6) seq_bits[arms] = o_step_idx[0];
                arms++;
                if (arms == 6) loop_en = 1'b0;
            end
            if (o_seq_done) begin
                dones++;
                if (arms < 6) early++;
            end
        end
        check("loop idx sequence", {26'd0, seq_bits}, 32'b101010);
        check("loop step count", arms, 6);
        check("loop seq_done count", dones, 1);
        check("loop early seq_done", early, 0);
        check("loop back to idle", {31'd0, o_busy}, 32'd0);

        // Abort mid-RUN of step 1, then abort+start together from IDLE
        start_pulse();
        wait_sync(3'd1, "abort reach step1");
        @(negedge clk);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        check("abort outputs", {26'd0, o_busy, o_tmr_en, o_seq_done, o_step_idx}, 32'd0);
        dones = 0;
        repeat (10) begin @(negedge clk); if (o_seq_done || o_busy) dones++; end
        check("abort quiet", dones, 0);
        @(negedge clk); abort = 1'b1; start = 1'b1;
        @(posedge clk); #1; abort = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort beats start", {31'd0, o_busy}, 32'd0);

        // Rewrite the running entry, then reset mid-RUN
        wr_entry(0, {1'b0, MODE_AST, 4'd3, 4'd1, 8'd2});
        wr_entry(1, {1'b1, MODE_PWM, 4'd4, 4'd4, 8'd1});
        loop_en = 1'b1;
        start_pulse();
        wait_sync(3'd0, "rewrite reach step0");
        @(negedge clk); wr_en = 1'b1; wr_addr = 3'd0; wr_data = {1'b0, MODE_BURST, 4'd5, 4'd6, 8'd2};
        @(negedge clk); wr_en = 1'b0;
        check("active step held", {22'd0, o_tmr_mode, o_tmr_rate, o_tmr_duty}, {22'd0, 2'b01, 4'd3, 4'd1});
        wait_sync(3'd1, "rewrite reach step1");
        wait_sync(3'd0, "rewrite loop step0");
        check("rewritten entry used", {22'd0, o_tmr_mode, o_tmr_rate, o_tmr_duty}, {22'd0, 2'b11, 4'd5, 4'd6});
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; loop_en = 1'b0;
        @(negedge clk);
        check("reset mid-run outputs", {13'd0, act_vec()}, 32'd0);
        start_pulse();
        wait_sync(3'd0, "cleared table step0");
        check("cleared table entry", {13'd0, act_vec()}, {13'd0, mk(1, 1, 1, 1, 0, 3'd0, 2'b00, 4'd0, 4'd0, 0)});
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ne555_seq_ctrl.md
Name: ne555_seq_ctrl

Overview:
Step sequencer that drives the control inputs of one NE555EX-style timer core: mode, rate, duty, enable, fire and sync.
- Holds a small programmable table of steps.
- Each step selects a timer mode/rate/duty and a duration.
- Steps play back in order, with optional looping, and feed the timer's done output back for monostable steps.
- Sits between the register/pin front-end and the timer core, replacing direct pin control of those inputs.

Parameters:
- DEPTH, 8: number of step table entries; power of 2, ≥2.
- TICK_DIV, 256: clk cycles per duration base tick; ≥2.
- AW, $clog2(DEPTH): table address width (derived).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write address
- wr_data  in  19  entry: [18] last, [17:16] mode, [15:12] rate, [11:8] duty, [7:0] dur
- start  in  1  begin sequence at entry 0 (level sampled each cycle)
- abort  in  1  stop immediately
- loop_en  in  1  restart at entry 0 after the final step
- clear_err  in  1  clear timeout_err
- tmr_done  in  1  timer DONE output (stretched pulse)
- tmr_en  out  1  timer local enable
- tmr_mode  out  2  timer MODE
- tmr_rate  out  4  timer RATE
- tmr_duty  out  4  timer DUTY
- tmr_fire  out  1  one-cycle trigger
- tmr_sync  out  1  one-cycle counter sync
- busy  out  1  high in every state except IDLE
- seq_done  out  1  one-cycle completion pulse
- step_idx  out  AW  index of the active entry
- timeout_err  out  1  sticky: a mono step ended on duration, not tmr_done

Behaviour:
Reset (rst=1 at a clk edge):
- State goes to IDLE.
- Table entries are cleared to 0.
- All outputs are 0, and ptr, dur_cnt and the prescaler are cleared.

FSM states: IDLE, LOAD, ARM, RUN, FINISH.
- IDLE: tmr_en=0.
  - start=1 → LOAD with ptr=0.
- LOAD (1 cycle): latch table[ptr] into the active mode/rate/duty/dur/last registers; clear dur_cnt and the prescaler. → ARM.
- ARM (1 cycle):
  - tmr_en=1 and tmr_sync=1.
  - tmr_fire=1 only if mode==00.
  - → RUN.
- RUN: tmr_en=1; tmr_mode/rate/duty come from the active registers.
  - The prescaler counts 0..TICK_DIV-1; a base tick occurs on wrap, and dur_cnt increments on each base tick.
  - dur_eff = (dur==0) ? 1 : dur.
  - Non-mono step: ends in the cycle of the dur_eff-th base tick, so RUN lasts exactly dur_eff*TICK_DIV cycles.
  - Mono step: ends on the first cycle where tmr_done rises (0→1), using a registered previous value.
  - Mono step, otherwise: ends at the dur_eff-th base tick as a timeout and sets timeout_err.
  - tmr_done rise and a timeout in the same cycle: treated as done; timeout_err not set.
  - Step end, not final: ptr+1 → LOAD.
  - A step is final if last=1 or ptr==DEPTH-1.
  - Final step, loop_en=1: ptr=0 → LOAD.
  - Final step, loop_en=0: → FINISH.
- FINISH (1 cycle): seq_done=1, tmr_en=0. → IDLE.

Priorities:
- abort has priority in every state: next state is IDLE, tmr_en=0 from the next cycle, no seq_done, ptr cleared.
- abort and start in the same cycle: abort wins.
- start while busy is ignored.

Outputs and registers:
- step_idx = ptr.
- tmr_mode/rate/duty hold their last values in IDLE, and are 0 after reset.
- timeout_err clears on clear_err; a set event in the same cycle wins.

Table writes:
- Accepted in any state.
- A write to the active entry does not alter the running step; it is used on that entry's next LOAD.
- The read in LOAD and a write to the same address in the same cycle return the old data.

Timing:
- Step boundary overhead is 2 cycles (LOAD + ARM); the timer sees tmr_sync at each step start.

Decomposition:
- Package ne555_pkg:
  - seq_state_t enum.
  - Mode constants MODE_MONO=2'b00, MODE_AST=2'b01, MODE_PWM=2'b10, MODE_BURST=2'b11.
  - Entry field offsets/widths and packed struct seq_entry_t (19 bits).
- Sub-module ne555_seq_table: DEPTH×19 register file with synchronous clear, one write port, one combinational read port.
- FSM, prescaler and counters live in the top.

Test Plan:
1. TICK_DIV=4. Table entry0 = {last=0, AST, rate=2, duty=0, dur=3}, entry1 = {last=1, PWM, rate=1, duty=8, dur=2}. Pulse start.
   → entry0: tmr_sync at cycle 2, tmr_mode=01 for 12 RUN cycles.
   → entry1: tmr_duty=8 for 8 RUN cycles.
   → seq_done one pulse, busy falls the next cycle.
2. Mono step, dur=10. Raise tmr_done 5 base ticks after tmr_fire.
   → step ends on the tmr_done rise; timeout_err stays 0.
   → Repeat without tmr_done: step ends after 40 cycles and timeout_err=1 until clear_err.
3. loop_en=1, two-step table, run 3 iterations.
   → step_idx sequence 0,1,0,1,0,1; no seq_done.
   → Drop loop_en during the last step: seq_done after step 1.
4. Assert abort mid-RUN of step 1.
   → Next cycle: IDLE, tmr_en=0, busy=0, step_idx=0, no seq_done.
   → abort+start in the same cycle from IDLE: stays IDLE.
5. Entry with dur=0 → RUN lasts 4 cycles. DEPTH entries all last=0 → sequence ends after entry 7.
6. Write entry0 while entry0 is running → current step unchanged; new values appear on the next loop's LOAD. rst mid-RUN → all outputs 0 and table cleared on the next cycle.
